// File: rtl/sram_controller.sv
// sram_controller: sequences 32-bit loads/stores as two half-word accesses to a 16-bit async SRAM with wait states.
module sram_controller #(
  parameter int ADDR_BASE   = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N,
  output logic        SRAM_OE_N
);
  localparam logic [1:0] IDLE = 2'd0, LOW = 2'd1, HIGH = 2'd2, DONE = 2'd3;
  logic [1:0]  state;
  logic [2:0]  wcnt;
  logic [16:0] w_q;
  logic [31:0] data_q;
  logic        wr_q;
  logic        phase;
  logic        last;
  assign phase     = (state == LOW) || (state == HIGH);
  assign last      = wcnt == 3'(WAIT_CYCLES);
  assign SRAM_ADDR = state == LOW ? {w_q, 1'b0} : state == HIGH ? {w_q, 1'b1} : '0;
  assign SRAM_WE_N = ~(phase & wr_q);
  assign SRAM_OE_N = ~(phase & ~wr_q);
  assign SRAM_DQ   = ~SRAM_WE_N ? (state == HIGH ? data_q[31:16] : data_q[15:0]) : 'z;
  // combinational in IDLE so the pipeline freezes in the request cycle itself
  assign ready     = state == IDLE ? ~(rd_en | wr_en) : state == DONE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wcnt      <= '0;
      w_q       <= '0;
      data_q    <= '0;
      wr_q      <= 1'b0;
      read_data <= '0;
    end else begin
      case (state)
        IDLE: if (rd_en | wr_en) begin
          w_q    <= 17'((address - 32'(ADDR_BASE)) >> 2);
          data_q <= write_data;
          wr_q   <= wr_en;
          wcnt   <= '0;
          state  <= LOW;
        end
        LOW: begin
          if (!wr_q && last) read_data[15:0] <= SRAM_DQ;
          wcnt  <= last ? 3'd0 : wcnt + 3'd1;
          state <= last ? HIGH : LOW;
        end
        HIGH: begin
          if (!wr_q && last) read_data[31:16] <= SRAM_DQ;
          wcnt  <= last ? 3'd0 : wcnt + 3'd1;
          state <= last ? DONE : HIGH;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller: directed checks of the SRAM controller against a behavioural async SRAM.
module tb_sram_controller;
  logic        clk = 0, rst = 1;
  logic        rd_en = 0, wr_en = 0;
  logic [31:0] address = 0, write_data = 0;
  logic [31:0] read_data;
  logic        ready, we_n, oe_n;
  logic [17:0] sram_addr;
  wire  [15:0] dq;
  logic [15:0] mem [0:1023];
  logic        rd1 = 0, wr1 = 0;
  logic [31:0] addr1 = 0, wd1 = 0;
  logic [31:0] rdata1;
  logic        ready1, we1_n, oe1_n;
  logic [17:0] sram_addr1;
  wire  [15:0] dq1;
  logic [15:0] mem1 [0:1023];
  int vectors = 0, errors = 0;

  always #5 clk = ~clk;

  sram_controller #(.ADDR_BASE(1024), .WAIT_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready), .SRAM_DQ(dq),
    .SRAM_ADDR(sram_addr), .SRAM_WE_N(we_n), .SRAM_OE_N(oe_n));

  sram_controller #(.ADDR_BASE(1024), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .rd_en(rd1), .wr_en(wr1), .address(addr1),
    .write_data(wd1), .read_data(rdata1), .ready(ready1), .SRAM_DQ(dq1),
    .SRAM_ADDR(sram_addr1), .SRAM_WE_N(we1_n), .SRAM_OE_N(oe1_n));

  // released bus floats high so a stray driver is visible
  pullup (dq);
  assign dq  = !oe_n  ? mem[sram_addr[9:0]]   : 'z;
  assign dq1 = !oe1_n ? mem1[sram_addr1[9:0]] : 'z;
  always @(posedge clk) if (!we_n) mem[sram_addr[9:0]] <= dq;

  task automatic do_access(input logic r, input logic wv, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    rd_en = r; wr_en = wv; address = a; write_data = d;
    for (int c = 1; c <= 5; c++) @(negedge clk);
    rd_en = 0; wr_en = 0;
  endtask

  task automatic test_initial_reset;
    #1;
    vectors++;
    if (ready !== 1'b1 || read_data !== 32'h0 || we_n !== 1'b1 || oe_n !== 1'b1 || sram_addr !== 18'h0) begin
      errors++;
      $display("FAIL init_reset: ready=%b rd=%h we_n=%b oe_n=%b addr=%h", ready, read_data, we_n, oe_n, sram_addr);
    end
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  task automatic test_store;
    @(negedge clk);
    wr_en = 1; address = 1024; write_data = 32'hDEADBEEF;
    for (int c = 0; c <= 5; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      vectors++;
      if (ready !== (c == 5) || we_n !== !(c >= 1 && c <= 4)) begin
        errors++;
        $display("FAIL store_timing C%0d: ready=%b we_n=%b", c, ready, we_n);
      end
      if (c == 1 || c == 3) begin
        vectors++;
        if (dq !== (c == 1 ? 16'hBEEF : 16'hDEAD)) begin
          errors++;
          $display("FAIL store_dq C%0d: got %h", c, dq);
        end
      end
    end
    wr_en = 0;
    @(negedge clk);
    vectors++;
    if (mem[0] !== 16'hBEEF || mem[1] !== 16'hDEAD || read_data !== 32'h0) begin
      errors++;
      $display("FAIL store_mem: hw0=%h hw1=%h rd=%h want BEEF DEAD 0", mem[0], mem[1], read_data);
    end
  endtask

  task automatic test_load;
    @(negedge clk);
    rd_en = 1; address = 1024;
    for (int c = 1; c <= 5; c++) @(negedge clk);
    #1;
    vectors++;
    if (ready !== 1'b1 || read_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL load_c5: ready=%b rd=%h want 1 DEADBEEF", ready, read_data);
    end
    rd_en = 0;
    repeat (3) @(negedge clk);
    vectors++;
    if (read_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL load_hold: rd=%h want DEADBEEF", read_data);
    end
    do_access(0, 1, 1028, 32'h12345678);
    @(negedge clk);
    rd_en = 1; address = 1028;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      #1;
      if (c == 1 || c == 3) begin
        vectors++;
        if (sram_addr !== (c == 1 ? 18'd2 : 18'd3) || oe_n !== 1'b0) begin
          errors++;
          $display("FAIL load_addr C%0d: addr=%0d oe_n=%b", c, sram_addr, oe_n);
        end
      end
    end
    vectors++;
    if (read_data !== 32'h12345678) begin
      errors++;
      $display("FAIL load_1028: rd=%h want 12345678", read_data);
    end
    rd_en = 0;
  endtask

  task automatic test_both;
    do_access(1, 1, 1032, 32'h0BADF00D);
    @(negedge clk);
    vectors++;
    if (mem[4] !== 16'hF00D || mem[5] !== 16'h0BAD || read_data !== 32'h12345678) begin
      errors++;
      $display("FAIL both_en: hw4=%h hw5=%h rd=%h want F00D 0BAD 12345678", mem[4], mem[5], read_data);
    end
  endtask

  task automatic test_no_restart;
    int lows = 0;
    @(negedge clk);
    rd_en = 1; address = 1024;
    for (int c = 0; c <= 12; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (!oe_n) lows++;
      if (c == 5) rd_en = 0;
    end
    vectors++;
    if (lows != 4 || read_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL no_restart: oe_low_cycles=%0d rd=%h want 4 DEADBEEF", lows, read_data);
    end
    @(negedge clk);
    rd_en = 1; address = 1028;
    for (int c = 0; c <= 7; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (c == 5) begin
        vectors++;
        if (read_data !== 32'h12345678 || ready !== 1'b1) begin
          errors++;
          $display("FAIL held_c5: rd=%h ready=%b", read_data, ready);
        end
      end
      if (c == 6) begin
        vectors++;
        if (ready !== 1'b0 || oe_n !== 1'b1) begin
          errors++;
          $display("FAIL held_c6: ready=%b oe_n=%b want 0 1", ready, oe_n);
        end
      end
      if (c == 7) begin
        vectors++;
        if (oe_n !== 1'b0 || sram_addr !== 18'd2) begin
          errors++;
          $display("FAIL held_c7: oe_n=%b addr=%0d want 0 2", oe_n, sram_addr);
        end
      end
    end
    rd_en = 0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset;
    #2 rst = 1;
    #1;
    vectors++;
    if (ready !== 1'b1 || read_data !== 32'h0 || we_n !== 1'b1 || oe_n !== 1'b1 || dq !== 16'hFFFF) begin
      errors++;
      $display("FAIL async_reset: ready=%b rd=%h we_n=%b oe_n=%b dq=%h", ready, read_data, we_n, oe_n, dq);
    end
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset_mid_store;
    @(negedge clk);
    wr_en = 1; address = 1024; write_data = 32'hAAAA5555;
    repeat (3) @(negedge clk);
    #2;
    vectors++;
    if (we_n !== 1'b0 || dq !== 16'hAAAA) begin
      errors++;
      $display("FAIL mid_store_c3: we_n=%b dq=%h want 0 AAAA", we_n, dq);
    end
    rst = 1; wr_en = 0;
    #1;
    vectors++;
    if (we_n !== 1'b1 || dq !== 16'hFFFF || ready !== 1'b1 || sram_addr !== 18'h0) begin
      errors++;
      $display("FAIL mid_store_reset: we_n=%b dq=%h ready=%b addr=%h", we_n, dq, ready, sram_addr);
    end
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    vectors++;
    if (mem[0] !== 16'h5555 || mem[1] !== 16'hDEAD) begin
      errors++;
      $display("FAIL mid_store_mem: hw0=%h hw1=%h want 5555 DEAD", mem[0], mem[1]);
    end
  endtask

  task automatic test_zero_wait;
    @(negedge clk);
    rd1 = 1; addr1 = 1036;
    for (int c = 0; c <= 4; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      vectors++;
      if (ready1 !== (c == 3 || c == 4) || oe1_n !== !(c == 1 || c == 2)) begin
        errors++;
        $display("FAIL zero_wait C%0d: ready=%b oe_n=%b", c, ready1, oe1_n);
      end
      if (c == 2) begin
        vectors++;
        if (sram_addr1 !== 18'd7) begin
          errors++;
          $display("FAIL zero_wait_addr: addr=%0d want 7", sram_addr1);
        end
      end
      if (c == 3) begin
        vectors++;
        if (rdata1 !== 32'hCAFEBABE) begin
          errors++;
          $display("FAIL zero_wait_data: rd=%h want CAFEBABE", rdata1);
        end
        rd1 = 0;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i] = 16'h0;
      mem1[i] = 16'h0;
    end
    mem1[6] = 16'hBABE;
    mem1[7] = 16'hCAFE;
    test_initial_reset;
    test_store;
    test_load;
    test_both;
    test_no_restart;
    test_reset;
    test_reset_mid_store;
    test_zero_wait;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
